// File: rtl/stage_loader.sv
// Stage loader: clears every object slot table, then streams one stage's records from a
// synchronous ROM into per-type slot writes and scalar registers. Optional: STAGE_LOADER_CHECKSUM_EN.
module stage_loader #(
  parameter int COORD_W     = 13,
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_W     = 2,
  parameter int STAGE_DEPTH = 256,
  parameter int ADDR_W      = 10,
  parameter int MAX_SLOTS   = 64,
  parameter int SLOT_W      = 6,
  parameter int MAX_ENEMY   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_req,
  input  logic [STAGE_W-1:0] stage_sel,
  output logic               busy,
  output logic               done,
  output logic               rom_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [31:0]        rom_data,
  output logic               obj_we,
  output logic [3:0]         obj_type,
  output logic [SLOT_W-1:0]  obj_idx,
  output logic [COORD_W-1:0] obj_x,
  output logic [COORD_W-1:0] obj_y,
  output logic [1:0]         obj_state,
  output logic [COORD_W-1:0] mario_x,
  output logic [COORD_W-1:0] mario_y,
  output logic [COORD_W-1:0] castle_x,
  output logic [COORD_W-1:0] castle_y,
  output logic [COORD_W-1:0] map_width,
  output logic               err_overflow,
`ifdef STAGE_LOADER_CHECKSUM_EN
  output logic               err_checksum,
`endif
  output logic               err_noend
);

  localparam int OFF_W     = $clog2(STAGE_DEPTH);
  localparam int CNT_W     = SLOT_W + 1;
  localparam int NUM_LISTS = 5;

  localparam logic [3:0] R_END    = 4'd0;
  localparam logic [3:0] R_MARIO  = 4'd1;
  localparam logic [3:0] R_GOOMBA = 4'd2;
  localparam logic [3:0] R_TURTLE = 4'd3;
  localparam logic [3:0] R_BOX    = 4'd4;
  localparam logic [3:0] R_PIPE   = 4'd5;
  localparam logic [3:0] R_COIN   = 4'd6;
  localparam logic [3:0] R_CASTLE = 4'd7;
  localparam logic [3:0] R_MAPW   = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_STREAM, S_DONE} state_e;

  if (NUM_STAGES > (1 << STAGE_W) || NUM_STAGES * STAGE_DEPTH > (1 << ADDR_W)) begin : g_param_check
    $error("stage_loader: STAGE_W or ADDR_W too narrow for NUM_STAGES*STAGE_DEPTH");
  end

  state_e             r_state;
  logic               r_busy, r_done;
  logic               r_fetch_en, r_dec_valid;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic [OFF_W-1:0]   r_offset;
  logic [STAGE_W-1:0] r_stage;
  logic               r_obj_we;
  logic [3:0]         r_obj_type;
  logic [SLOT_W-1:0]  r_obj_idx;
  logic [COORD_W-1:0] r_obj_x, r_obj_y;
  logic [1:0]         r_obj_state;
  logic [COORD_W-1:0] r_mario_x, r_mario_y, r_castle_x, r_castle_y, r_map_width;
  logic               r_err_overflow, r_err_noend;
  logic [CNT_W-1:0]   r_cnt [NUM_LISTS];
`ifdef STAGE_LOADER_CHECKSUM_EN
  logic [27:0]        r_xor;
  logic               r_err_checksum;
`endif

  logic [3:0]         w_type;
  logic [COORD_W-1:0] w_x, w_y;
  logic [1:0]         w_state;
  logic               w_is_list;
  logic [2:0]         w_lidx;
  logic [CNT_W-1:0]   w_limit, w_cnt_cur;
  logic               w_room, w_end_hit;
  logic [ADDR_W-1:0]  w_base;

  assign w_type    = rom_data[31:28];
  assign w_x       = rom_data[27:15];
  assign w_y       = rom_data[14:2];
  assign w_state   = rom_data[1:0];
  assign w_base    = ADDR_W'(r_stage) * ADDR_W'(STAGE_DEPTH);
  assign w_end_hit = r_dec_valid && (w_type == R_END);

  always_comb begin
    // NOTE: every signal gets its default first, so no path through the block can infer a latch.
    w_is_list = 1'b0;
    w_limit   = CNT_W'(MAX_ENEMY);
    w_lidx    = '0;
    case (w_type)
      R_GOOMBA, R_TURTLE, R_PIPE: w_is_list = 1'b1;
      R_BOX, R_COIN: begin
        w_is_list = 1'b1;
        w_limit   = CNT_W'(MAX_SLOTS);
      end
      default: ;
    endcase
    if (w_is_list) w_lidx = w_type[2:0] - 3'd2;
  end

  assign w_cnt_cur = r_cnt[w_lidx];
  assign w_room    = w_cnt_cur < w_limit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_fetch_en     <= 1'b0;
      r_dec_valid    <= 1'b0;
      r_rom_addr     <= '0;
      r_offset       <= '0;
      r_stage        <= '0;
      r_obj_we       <= 1'b0;
      r_obj_type     <= '0;
      r_obj_idx      <= '0;
      r_obj_x        <= '0;
      r_obj_y        <= '0;
      r_obj_state    <= '0;
      r_mario_x      <= '0;
      r_mario_y      <= '0;
      r_castle_x     <= '0;
      r_castle_y     <= '0;
      r_map_width    <= '0;
      r_err_overflow <= 1'b0;
      r_err_noend    <= 1'b0;
      // NOTE: the per-type counters are a few flops, not a RAM, so each one is reset explicitly.
      for (int i = 0; i < NUM_LISTS; i++) r_cnt[i] <= '0;
`ifdef STAGE_LOADER_CHECKSUM_EN
      r_xor          <= '0;
      r_err_checksum <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses <= only, so every branch below reads the pre-edge r_* values.
      r_done   <= 1'b0;
      r_obj_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_req) begin
            r_state        <= S_CLEAR;
            r_busy         <= 1'b1;
            r_stage        <= stage_sel;
            r_obj_we       <= 1'b1;
            r_obj_type     <= '0;
            r_obj_idx      <= '0;
            r_obj_x        <= '0;
            r_obj_y        <= '0;
            r_obj_state    <= '0;
            r_mario_x      <= '0;
            r_mario_y      <= '0;
            r_castle_x     <= '0;
            r_castle_y     <= '0;
            r_map_width    <= '0;
            r_err_overflow <= 1'b0;
            r_err_noend    <= 1'b0;
            for (int i = 0; i < NUM_LISTS; i++) r_cnt[i] <= '0;
`ifdef STAGE_LOADER_CHECKSUM_EN
            r_xor          <= '0;
            r_err_checksum <= 1'b0;
`endif
          end
        end

        S_CLEAR: begin
          if (r_obj_idx == SLOT_W'(MAX_SLOTS - 1)) begin
            r_state    <= S_STREAM;
            r_fetch_en <= 1'b1;
            r_rom_addr <= w_base;
            r_offset   <= '0;
          end else begin
            r_obj_we  <= 1'b1;
            r_obj_idx <= r_obj_idx + 1'b1;
          end
        end

        S_STREAM: begin
          r_dec_valid <= rom_en;
          // Address holds at the last word of the stage rather than running into the next one.
          if (rom_en) begin
            if (r_offset == OFF_W'(STAGE_DEPTH - 1)) begin
              r_fetch_en <= 1'b0;
            end else begin
              r_rom_addr <= r_rom_addr + 1'b1;
              r_offset   <= r_offset + 1'b1;
            end
          end
          if (r_dec_valid) begin
            if (w_type == R_END) begin
              r_fetch_en <= 1'b0;
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
`ifdef STAGE_LOADER_CHECKSUM_EN
              r_err_checksum <= (rom_data[27:0] != r_xor);
`endif
            end else begin
`ifdef STAGE_LOADER_CHECKSUM_EN
              r_xor <= r_xor ^ rom_data[27:0];
`endif
              case (w_type)
                R_MARIO: begin
                  r_mario_x <= w_x;
                  r_mario_y <= w_y;
                end
                R_CASTLE: begin
                  r_castle_x <= w_x;
                  r_castle_y <= w_y;
                end
                R_MAPW: r_map_width <= w_x;
                default: ;
              endcase
              if (w_is_list) begin
                if (w_room) begin
                  r_obj_we      <= 1'b1;
                  r_obj_type    <= w_type;
                  r_obj_idx     <= w_cnt_cur[SLOT_W-1:0];
                  r_obj_x       <= w_x;
                  r_obj_y       <= w_y;
                  r_obj_state   <= (w_type == R_BOX) ? w_state : 2'd0;
                  r_cnt[w_lidx] <= w_cnt_cur + 1'b1;
                end else begin
                  r_err_overflow <= 1'b1;
                end
              end
              // Fetching has stopped and this last word was not END: the stage is unterminated.
              if (!r_fetch_en) begin
                r_state     <= S_DONE;
                r_done      <= 1'b1;
                r_busy      <= 1'b0;
                r_err_noend <= 1'b1;
              end
            end
          end
        end

        S_DONE: begin
          r_state     <= S_IDLE;
          r_dec_valid <= 1'b0;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // rom_en drops combinationally on END so the already prefetched word is simply never used.
  assign rom_en       = r_fetch_en & ~w_end_hit;
  assign rom_addr     = r_rom_addr;
  assign busy         = r_busy;
  assign done         = r_done;
  assign obj_we       = r_obj_we;
  assign obj_type     = r_obj_type;
  assign obj_idx      = r_obj_idx;
  assign obj_x        = r_obj_x;
  assign obj_y        = r_obj_y;
  assign obj_state    = r_obj_state;
  assign mario_x      = r_mario_x;
  assign mario_y      = r_mario_y;
  assign castle_x     = r_castle_x;
  assign castle_y     = r_castle_y;
  assign map_width    = r_map_width;
  assign err_overflow = r_err_overflow;
  assign err_noend    = r_err_noend;
`ifdef STAGE_LOADER_CHECKSUM_EN
  assign err_checksum = r_err_checksum;
`endif

endmodule

// File: tb/tb_stage_loader.sv
// Self-checking bench for stage_loader: a record-level model of each load (expected slot
// writes, scalars, flags, done cycle) is compared against the DUT on every cycle.
module tb_stage_loader;

  localparam int COORD_W     = 13;
  localparam int NUM_STAGES  = 4;
  localparam int STAGE_W     = 2;
  localparam int STAGE_DEPTH = 256;
  localparam int ADDR_W      = 10;
  localparam int MAX_SLOTS   = 64;
  localparam int SLOT_W      = 6;
  localparam int MAX_ENEMY   = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               load_req = 1'b0;
  logic [STAGE_W-1:0] stage_sel = '0;
  logic               busy, done, rom_en, obj_we;
  logic [ADDR_W-1:0]  rom_addr;
  logic [31:0]        rom_data = '0;
  logic [3:0]         obj_type;
  logic [SLOT_W-1:0]  obj_idx;
  logic [COORD_W-1:0] obj_x, obj_y, mario_x, mario_y, castle_x, castle_y, map_width;
  logic [1:0]         obj_state;
  logic               err_overflow, err_noend;
`ifdef STAGE_LOADER_CHECKSUM_EN
  logic               err_checksum;
`endif

  stage_loader #(
    .COORD_W(COORD_W), .NUM_STAGES(NUM_STAGES), .STAGE_W(STAGE_W), .STAGE_DEPTH(STAGE_DEPTH),
    .ADDR_W(ADDR_W), .MAX_SLOTS(MAX_SLOTS), .SLOT_W(SLOT_W), .MAX_ENEMY(MAX_ENEMY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .stage_sel(stage_sel),
    .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .obj_we(obj_we), .obj_type(obj_type), .obj_idx(obj_idx), .obj_x(obj_x), .obj_y(obj_y),
    .obj_state(obj_state), .mario_x(mario_x), .mario_y(mario_y), .castle_x(castle_x),
    .castle_y(castle_y), .map_width(map_width), .err_overflow(err_overflow),
`ifdef STAGE_LOADER_CHECKSUM_EN
    .err_checksum(err_checksum),
`endif
    .err_noend(err_noend)
  );

  always #5 clk = ~clk;

  // Synchronous level ROM: data valid one cycle after rom_en.
  logic [31:0] rom [NUM_STAGES*STAGE_DEPTH];
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  typedef struct {
    logic [3:0]         t;
    logic [SLOT_W-1:0]  idx;
    logic [COORD_W-1:0] x, y;
    logic [1:0]         st;
  } wr_t;

  wr_t exp_q[$];
  wr_t cur_w;
  int  n_cmp = 0, n_bad = 0;
  int  m_cyc, m_done_cyc, m_recs, m_fetch, m_base;
  bit  m_active = 0, chk_en = 0;
  logic [COORD_W-1:0] e_mx, e_my, e_cx, e_cy, e_mw;
  bit  e_ovf, e_noend, e_cks;
  int  obs_done_cyc, obs_goomba_writes;
  logic [COORD_W-1:0] obs_box_x, obs_box_y;
  logic [1:0] obs_box_st;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rec(input int t, input int x, input int y, input int st);
    return {t[3:0], x[12:0], y[12:0], st[1:0]};
  endfunction

  // END word carrying the XOR of the n preceding records, optionally with one bit wrong.
  function automatic logic [31:0] end_rec(input int s, input int n, input bit bad);
    logic [27:0] acc = '0;
    logic [27:0] flip = '0;
    for (int k = 0; k < n; k++) acc ^= rom[s*STAGE_DEPTH+k][27:0];
    if (bad) flip[$urandom_range(0, 27)] = 1'b1;
    return {4'd0, acc ^ flip};
  endfunction

  task automatic fill_random(input int s, input int n);
    for (int k = 0; k < STAGE_DEPTH; k++)
      rom[s*STAGE_DEPTH+k] = rec($urandom_range(1, 10), $urandom, $urandom, $urandom);
    if (n < STAGE_DEPTH) rom[s*STAGE_DEPTH+n] = end_rec(s, n, bit'($urandom_range(0, 1)));
  endtask

  // Reference model: walk the stage's records and derive every expected effect of the load.
  task automatic model_load(input int s);
    int cnt[16];
    int t, lim;
    bit found;
    logic [31:0] w;
    logic [27:0] acc;
    wr_t e;
    exp_q.delete();
    for (int i = 0; i < MAX_SLOTS; i++) begin
      e.t = 4'd0; e.idx = SLOT_W'(i); e.x = '0; e.y = '0; e.st = 2'd0;
      exp_q.push_back(e);
    end
    foreach (cnt[i]) cnt[i] = 0;
    {e_mx, e_my, e_cx, e_cy, e_mw} = '0;
    e_ovf = 0; e_cks = 0; found = 0; acc = '0;
    m_base = s * STAGE_DEPTH;
    m_recs = STAGE_DEPTH;
    for (int k = 0; k < STAGE_DEPTH && !found; k++) begin
      w = rom[m_base+k];
      t = int'(w[31:28]);
      if (t == 0) begin
        found = 1; m_recs = k + 1; e_cks = (w[27:0] != acc);
      end else begin
        acc ^= w[27:0];
        if (t == 1) begin e_mx = w[27:15]; e_my = w[14:2]; end
        else if (t == 7) begin e_cx = w[27:15]; e_cy = w[14:2]; end
        else if (t == 8) e_mw = w[27:15];
        else if (t >= 2 && t <= 6) begin
          lim = (t == 4 || t == 6) ? MAX_SLOTS : MAX_ENEMY;
          if (cnt[t] < lim) begin
            e.t = t[3:0]; e.idx = SLOT_W'(cnt[t]); e.x = w[27:15]; e.y = w[14:2];
            e.st = (t == 4) ? w[1:0] : 2'd0;
            exp_q.push_back(e);
            cnt[t]++;
          end else e_ovf = 1;
        end
      end
    end
    e_noend = !found;
    m_done_cyc = 1 + MAX_SLOTS + m_recs + 1;
  endtask

  // Compare process: every cycle, against the model of the load in progress (or idle).
  always @(negedge clk) begin
    if (chk_en) begin
      if (m_active) begin
        m_cyc++;
        if (obj_we) begin
          if (exp_q.size() == 0) check("extra_write", 1'b1, 1'b0);
          else begin
            cur_w = exp_q.pop_front();
            check("wr_type", obj_type, cur_w.t);
            check("wr_idx", obj_idx, cur_w.idx);
            check("wr_x", obj_x, cur_w.x);
            check("wr_y", obj_y, cur_w.y);
            check("wr_state", obj_state, cur_w.st);
            if (obj_type == 4'd4 && obj_idx == '0) begin
              obs_box_x = obj_x; obs_box_y = obj_y; obs_box_st = obj_state;
            end
            if (obj_type == 4'd2) obs_goomba_writes++;
          end
        end
        if (rom_en) begin
          check("rom_addr", rom_addr, m_base + m_fetch);
          m_fetch++;
        end
        check("busy", busy, m_cyc < m_done_cyc);
        check("done", done, m_cyc == m_done_cyc);
        if (done) obs_done_cyc = m_cyc;
        if (m_cyc == m_done_cyc) begin
          check("pending_writes", exp_q.size(), 0);
          check("fetch_count", m_fetch, m_recs);
          check("mario_x", mario_x, e_mx);
          check("mario_y", mario_y, e_my);
          check("castle_x", castle_x, e_cx);
          check("castle_y", castle_y, e_cy);
          check("map_width", map_width, e_mw);
          check("err_overflow", err_overflow, e_ovf);
          check("err_noend", err_noend, e_noend);
`ifdef STAGE_LOADER_CHECKSUM_EN
          check("err_checksum", err_checksum, e_cks);
`endif
          m_active = 0;
        end
      end else begin
        check("idle_busy", busy, 1'b0);
        check("idle_done", done, 1'b0);
        check("idle_we", obj_we, 1'b0);
        check("idle_rom_en", rom_en, 1'b0);
      end
    end
  end

  task automatic start_load(input int s);
    @(negedge clk); #1;
    model_load(s);
    obs_done_cyc = -1; obs_goomba_writes = 0;
    obs_box_x = '0; obs_box_y = '0; obs_box_st = '0;
    stage_sel = STAGE_W'(s); load_req = 1'b1;
    m_cyc = 0; m_fetch = 0; m_active = 1;
    @(negedge clk); #1;
    load_req = 1'b0; stage_sel = STAGE_W'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1000 && m_active; i++) @(negedge clk);
    #1;
    check("load_finished", m_active, 1'b0);
    m_active = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_rom_en", rom_en, 1'b0);
    check("rst_we", obj_we, 1'b0);
    check("rst_scalars", {mario_x, mario_y, castle_x, castle_y, map_width}, '0);
    check("rst_errors", {err_overflow, err_noend}, '0);
    #1 rst_n = 1'b1;
    chk_en = 1;

    fill_random(0, 60);
    rom[0] = rec(1, 1234, 567, 0);
    rom[1] = rec(8, 3000, 0, 0);
    rom[2] = rec(7, 2900, 100, 0);
    rom[60] = end_rec(0, 60, 0);
    rom[256+0] = rec(1, 80, 439, 0);
    rom[256+1] = rec(4, 320, 359, 3);
    rom[256+2] = rec(2, 720, 439, 0);
    rom[256+3] = rec(8, 4680, 0, 0);
    rom[256+4] = end_rec(1, 4, 0);
    for (int k = 0; k < 17; k++) rom[512+k] = rec(2, 100 + 16*k, 400, 1);
    rom[512+17] = end_rec(2, 17, 0);
    fill_random(3, STAGE_DEPTH);

    // Reset in the middle of STREAM aborts the load.
    start_load(0);
    repeat (MAX_SLOTS + 12) @(negedge clk);
    #1 chk_en = 0; m_active = 0; rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_rom", {rom_en, rom_addr}, '0);
    check("midrst_obj", {obj_we, obj_type, obj_idx, obj_x, obj_y, obj_state}, '0);
    check("midrst_scalars", {mario_x, mario_y, castle_x, castle_y, map_width}, '0);
    check("midrst_errors", {err_overflow, err_noend}, '0);
    #1 rst_n = 1'b1; exp_q.delete(); chk_en = 1;
    repeat (400) @(negedge clk);

    start_load(1);
    wait_done();
    check("s1_done_cycle", obs_done_cyc, 71);
    check("s1_mario_x", mario_x, 80);
    check("s1_mario_y", mario_y, 439);
    check("s1_map_width", map_width, 4680);
    check("s1_box_x", obs_box_x, 320);
    check("s1_box_y", obs_box_y, 359);
    check("s1_box_state", obs_box_st, 3);
    check("s1_goombas", obs_goomba_writes, 1);

    start_load(2);
    wait_done();
    check("s2_overflow", err_overflow, 1'b1);
    check("s2_goomba_writes", obs_goomba_writes, MAX_ENEMY);

    // A load_req during CLEAR is ignored; flags from the previous load are cleared.
    start_load(1);
    repeat (10) @(negedge clk);
    #1 load_req = 1'b1; stage_sel = 2'd2;
    @(negedge clk); #1 load_req = 1'b0;
    wait_done();
    check("s1b_overflow", err_overflow, 1'b0);
    check("s1b_done_cycle", obs_done_cyc, 71);

    start_load(3);
    wait_done();
    check("s3_noend", err_noend, 1'b1);
    check("s3_done_cycle", obs_done_cyc, 1 + MAX_SLOTS + STAGE_DEPTH + 1);

`ifdef STAGE_LOADER_CHECKSUM_EN
    check("cks_clean", err_checksum, 1'b0);
`endif
    rom[256+1] ^= 32'h1;
    start_load(1);
    wait_done();
`ifdef STAGE_LOADER_CHECKSUM_EN
    check("cks_corrupt", err_checksum, 1'b1);
`endif
    check("corrupt_box_state", obs_box_st, 2);

    for (int it = 0; it < 8; it++) begin
      fill_random(0, $urandom_range(1, 200));
      if (it % 3 == 2) fill_random(3, $urandom_range(150, 256));
      start_load($urandom_range(0, NUM_STAGES - 1));
      wait_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stage_loader.md
Name: stage_loader

Overview:
Sequential, parametrised successor to the fixed combinational stage description. It holds no level data itself. On request it clears every object slot table, then streams one stage's object records from an external synchronous ROM. Each record is decoded into per-type slot writes for the game-object tables, and scalar stage registers (Mario start, castle, map width) are latched. It sits between the level ROM and the object/physics tables, so multiple stages can be selected at run time.

Parameters:
COORD_W, 13, coordinate width (x, y, map_width)
NUM_STAGES, 4, number of stages in ROM
STAGE_W, 2, width of stage_sel (clog2 NUM_STAGES)
STAGE_DEPTH, 256, record slots reserved per stage; stage s starts at address s*STAGE_DEPTH
ADDR_W, 10, ROM address width
MAX_SLOTS, 64, slots per type table; also the clear-phase length
SLOT_W, 6, width of obj_idx
MAX_ENEMY, 16, slot limit for goomba, turtle and pipe

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
load_req  in  1  start load; sampled only in IDLE
stage_sel  in  STAGE_W  stage to load; latched with load_req
busy  out  1  high from the cycle after load_req until done
done  out  1  one-cycle pulse when loading finishes
rom_en  out  1  ROM read enable
rom_addr  out  ADDR_W  ROM read address
rom_data  in  32  record word; valid 1 cycle after rom_en
obj_we  out  1  slot write strobe
obj_type  out  4  0=CLEAR, 2=GOOMBA, 3=TURTLE, 4=BOX, 5=PIPE, 6=COIN
obj_idx  out  SLOT_W  slot index within the type table
obj_x  out  COORD_W  x coordinate
obj_y  out  COORD_W  y coordinate
obj_state  out  2  box state: 0 coin, 1 pilz, 2 box, 3 stone; 0 for other types
mario_x, mario_y  out  COORD_W  Mario start position
castle_x, castle_y  out  COORD_W  castle position
map_width  out  COORD_W  stage width
err_overflow  out  1  sticky; a record was dropped because its table was full
err_noend  out  1  sticky; no END record within STAGE_DEPTH

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; all outputs 0, including errors, scalars and per-type counters. Reset mid-load aborts the load immediately; no done pulse.
- Record format: [31:28] type, [27:15] x, [14:2] y, [1:0] state.
- Record types: 0 END, 1 MARIO, 2 GOOMBA, 3 TURTLE, 4 BOX, 5 PIPE, 6 COIN, 7 CASTLE, 8 MAPW (x field carries the width). Types 9-15 are ignored.
- FSM states: IDLE -> CLEAR -> STREAM -> DONE -> IDLE.
- IDLE:
  - load_req=1 latches stage_sel, clears both error flags and all counters, and enters CLEAR.
  - load_req while busy is ignored.
- CLEAR:
  - Runs MAX_SLOTS cycles, i = 0..MAX_SLOTS-1.
  - Each cycle drives obj_we=1, obj_type=0, obj_idx=i, x=y=state=0. The consumer zeroes index i in every table; {x,y}=0 marks a slot disabled.
  - Scalars are zeroed on CLEAR entry.
- STREAM:
  - Pipelined: rom_en=1 every cycle, rom_addr increments from stage_sel*STAGE_DEPTH.
  - The record fetched in cycle n is decoded in cycle n+1, giving a sustained throughput of 1 record/cycle.
- Decode of a list type (2-6):
  - If cnt[type] < limit: write obj_idx=cnt[type] with x/y/state, then increment cnt[type].
  - Limit is MAX_ENEMY for goomba, turtle and pipe; MAX_SLOTS for box and coin.
  - Otherwise: no write, err_overflow set.
- Decode of a scalar type (1, 7, 8): register updated, obj_we=0. A later record of the same type overwrites the earlier one.
- END decoded: rom_en drops the same cycle and the in-flight prefetched word is discarded; enter DONE.
- No END after STAGE_DEPTH words: err_noend set, enter DONE.
- DONE: done=1 for one cycle, busy=0 the same cycle, return to IDLE. Scalars and errors hold until the next load_req or reset.
- Latency: load_req -> done = 1 + MAX_SLOTS + (records incl. END) + 1 cycles.

Optional Feature:
STAGE_LOADER_CHECKSUM_EN
- Defined:
  - The loader keeps a running XOR of all 32-bit words before END.
  - END's bits [27:0] carry the expected XOR[27:0].
  - On mismatch, extra output err_checksum (sticky, cleared on load_req/reset) is set. done still pulses.
- Undefined: port err_checksum is absent and END's low bits are ignored.

Test Plan:
- Reset mid-STREAM: drop rst_n for 1 cycle -> next cycle busy=0, all outputs 0, no done pulse.
- Stage 1, records {MARIO 80/439, BOX 320/359 st3, GOOMBA 720/439, MAPW 4680, END} -> 64 CLEAR writes; then BOX idx0 (x=320, y=359, state 3) and GOOMBA idx0; mario=80/439, map_width=4680; done exactly 1+64+5+1 = 71 cycles after load_req.
- 17 GOOMBA records then END -> writes idx0..15, 17th dropped, err_overflow=1, done pulses.
- Stage with no END in 256 words -> err_noend=1 at done; rom_addr never exceeds stage_base+255.
- load_req pulsed during CLEAR -> ignored, single done.
- With STAGE_LOADER_CHECKSUM_EN: corrupt one bit of a BOX word -> err_checksum=1; correct stream -> 0.
